// File: rtl/reg_pair_file.sv
// reg_pair_file: parametrised Game Boy CPU register file.
//
// Holds NUM_REGS byte registers, grouped as pairs p = {reg[2p], reg[2p+1]}
// (AF, BC, DE, HL with the default map). It provides byte and pair read/write,
// a pair +/-1 stepper (HL+/HL-, SP stepping), masking of the flag register's
// low bits, and a one-deep shadow bank for save/restore.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rd_sel / o_rd_data    RD_PORTS packed byte read ports
//   i_pair_rd_sel           pair read select; o_pair_rd_data = {hi, lo}
//   i_wr_*                  byte write port
//   i_pair_wr_*             pair write port
//   i_step_*                pair step (+1, or -1 when i_step_dec is set)
//   i_save, i_restore       shadow bank capture and restore
//   o_shadow_valid          shadow holds an unrestored snapshot
module reg_pair_file #(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        NUM_REGS  = 8,
  parameter int unsigned        RD_PORTS  = 3,
  parameter int unsigned        BYPASS    = 1,
  parameter int unsigned        FLAG_IDX  = 1,
  parameter logic [DATA_W-1:0]  FLAG_MASK = 8'hF0,
  localparam int unsigned       IDX_W     = $clog2(NUM_REGS),
  localparam int unsigned       PAIRS     = NUM_REGS / 2,
  localparam int unsigned       PIDX_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [RD_PORTS*IDX_W-1:0]    i_rd_sel,
  output logic [RD_PORTS*DATA_W-1:0]   o_rd_data,
  input  logic [PIDX_W-1:0]            i_pair_rd_sel,
  output logic [2*DATA_W-1:0]          o_pair_rd_data,
  input  logic                         i_wr_en,
  input  logic [IDX_W-1:0]             i_wr_sel,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_pair_wr_en,
  input  logic [PIDX_W-1:0]            i_pair_wr_sel,
  input  logic [2*DATA_W-1:0]          i_pair_wr_data,
  input  logic                         i_step_en,
  input  logic [PIDX_W-1:0]            i_step_sel,
  input  logic                         i_step_dec,
  input  logic                         i_save,
  input  logic                         i_restore,
  output logic                         o_shadow_valid
);

  localparam logic [2*DATA_W-1:0] PairOne = {{(2*DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs_q   [NUM_REGS];
  logic [DATA_W-1:0]   regs_d   [NUM_REGS];
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_src   [NUM_REGS];
  logic                shadow_valid_q;
  logic                do_restore;
  logic [IDX_W-1:0]    step_hi_idx, step_lo_idx;
  logic [IDX_W-1:0]    prd_hi_idx, prd_lo_idx;
  logic [2*DATA_W-1:0] step_cur, step_res;

  // A restore without a valid snapshot is ignored entirely.
  assign do_restore     = i_restore & shadow_valid_q;
  assign o_shadow_valid = shadow_valid_q;

  assign step_hi_idx = IDX_W'({i_step_sel, 1'b0});
  assign step_lo_idx = IDX_W'({i_step_sel, 1'b1});
  assign prd_hi_idx  = IDX_W'({i_pair_rd_sel, 1'b0});
  assign prd_lo_idx  = IDX_W'({i_pair_rd_sel, 1'b1});

  // Step always works from the stored pair, so back-to-back steps advance by one.
  always_comb begin
    step_cur = {regs_q[step_hi_idx], regs_q[step_lo_idx]};
    step_res = i_step_dec ? (step_cur - PairOne) : (step_cur + PairOne);
  end

  // Per-byte next state; later assignments override earlier ones, so the
  // order below is lowest priority first: step, byte write, pair write, restore.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i_step_en && (i_step_sel == PIDX_W'(i / 2))) begin
        regs_d[i] = (i % 2 == 0) ? step_res[2*DATA_W-1:DATA_W] : step_res[DATA_W-1:0];
      end
      if (i_wr_en && (i_wr_sel == IDX_W'(i))) begin
        regs_d[i] = i_wr_data;
      end
      if (i_pair_wr_en && (i_pair_wr_sel == PIDX_W'(i / 2))) begin
        regs_d[i] = (i % 2 == 0) ? i_pair_wr_data[2*DATA_W-1:DATA_W]
                                 : i_pair_wr_data[DATA_W-1:0];
      end
      if (do_restore) begin
        regs_d[i] = shadow_q[i];
      end
      if (i == FLAG_IDX) begin
        regs_d[i] = regs_d[i] & FLAG_MASK;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      shadow_valid_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      if (do_restore) begin
        shadow_valid_q <= 1'b0;
      end else if (i_save) begin
        // Snapshot is of the stored values, before this cycle's writes.
        shadow_q       <= regs_q;
        shadow_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      rd_src[i] = (BYPASS != 0) ? regs_d[i] : regs_q[i];
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int unsigned k = 0; k < RD_PORTS; k++) begin
      o_rd_data[k*DATA_W +: DATA_W] = rd_src[i_rd_sel[k*IDX_W +: IDX_W]];
    end
    o_pair_rd_data = {rd_src[prd_hi_idx], rd_src[prd_lo_idx]};
  end

endmodule

// File: tb/tb_reg_pair_file.sv
// Testbench for reg_pair_file. Two instances share all stimulus: dut0 has
// BYPASS=0 (stored reads), dut1 has BYPASS=1 (next-state reads). The driver
// pushes expected observations into a queue; a monitor on the falling edge
// pops them and compares against the selected instance's outputs.
module tb_reg_pair_file;

  logic        clk;
  logic        rst;
  logic [8:0]  rd_sel;
  logic [23:0] rd_data0, rd_data1;
  logic [1:0]  pair_rd_sel;
  logic [15:0] pair_rd_data0, pair_rd_data1;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        pair_wr_en;
  logic [1:0]  pair_wr_sel;
  logic [15:0] pair_wr_data;
  logic        step_en;
  logic [1:0]  step_sel;
  logic        step_dec;
  logic        save, restore;
  logic        sv0, sv1;

  typedef struct {
    string       name;
    int          dut;   // 0 = stored reads, 1 = bypass reads
    int          kind;  // 0 = byte read port, 1 = pair read, 2 = shadow valid
    int          port;
    logic [15:0] exp;
  } chk_t;

  chk_t q[$];
  int   errors = 0;
  int   checks = 0;

  reg_pair_file #(.BYPASS(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rd_sel(rd_sel), .o_rd_data(rd_data0),
    .i_pair_rd_sel(pair_rd_sel), .o_pair_rd_data(pair_rd_data0),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
    .i_pair_wr_en(pair_wr_en), .i_pair_wr_sel(pair_wr_sel), .i_pair_wr_data(pair_wr_data),
    .i_step_en(step_en), .i_step_sel(step_sel), .i_step_dec(step_dec),
    .i_save(save), .i_restore(restore), .o_shadow_valid(sv0)
  );

  reg_pair_file #(.BYPASS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rd_sel(rd_sel), .o_rd_data(rd_data1),
    .i_pair_rd_sel(pair_rd_sel), .o_pair_rd_data(pair_rd_data1),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
    .i_pair_wr_en(pair_wr_en), .i_pair_wr_sel(pair_wr_sel), .i_pair_wr_data(pair_wr_data),
    .i_step_en(step_en), .i_step_sel(step_sel), .i_step_dec(step_dec),
    .i_save(save), .i_restore(restore), .o_shadow_valid(sv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every pending expectation at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        c;
      logic [15:0] act;
      c = q.pop_front();
      case (c.kind)
        0:       act = {8'h00, (c.dut == 1) ? rd_data1[c.port*8 +: 8] : rd_data0[c.port*8 +: 8]};
        1:       act = (c.dut == 1) ? pair_rd_data1 : pair_rd_data0;
        default: act = {15'h0, (c.dut == 1) ? sv1 : sv0};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s (dut%0d): got 0x%04h, expected 0x%04h", c.name, c.dut, act, c.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_sel = 0; wr_data = 0;
    pair_wr_en = 0; pair_wr_sel = 0; pair_wr_data = 0;
    step_en = 0; step_sel = 0; step_dec = 0;
    save = 0; restore = 0;
  endtask

  task automatic expect_rd(input string n, input int d, input int port, input int sel,
                           input logic [7:0] e);
    chk_t c;
    rd_sel[port*3 +: 3] = 3'(sel);
    c.name = n; c.dut = d; c.kind = 0; c.port = port; c.exp = {8'h00, e};
    q.push_back(c);
  endtask

  task automatic expect_pair(input string n, input int d, input int p, input logic [15:0] e);
    chk_t c;
    pair_rd_sel = 2'(p);
    c.name = n; c.dut = d; c.kind = 1; c.port = 0; c.exp = e;
    q.push_back(c);
  endtask

  task automatic expect_sv(input string n, input int d, input logic e);
    chk_t c;
    c.name = n; c.dut = d; c.kind = 2; c.port = 0; c.exp = {15'h0, e};
    q.push_back(c);
  endtask

  task automatic pair_write(input int p, input logic [15:0] v);
    pair_wr_en = 1; pair_wr_sel = 2'(p); pair_wr_data = v;
  endtask

  task automatic byte_write(input int r, input logic [7:0] v);
    wr_en = 1; wr_sel = 3'(r); wr_data = v;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rd_sel = '0; pair_rd_sel = '0;
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;

    // Reset state.
    expect_rd("rst_r0", 0, 0, 0, 8'h00);
    expect_rd("rst_r1", 0, 1, 1, 8'h00);
    expect_rd("rst_r2", 0, 2, 2, 8'h00);
    expect_pair("rst_hl", 0, 3, 16'h0000);
    expect_sv("rst_sv", 0, 1'b0);
    cyc();
    expect_rd("rst_r3", 0, 0, 3, 8'h00);
    expect_rd("rst_r4", 0, 1, 4, 8'h00);
    expect_rd("rst_r5", 0, 2, 5, 8'h00);
    cyc();
    expect_rd("rst_r6", 0, 0, 6, 8'h00);
    expect_rd("rst_r7", 0, 1, 7, 8'h00);
    cyc();

    // Pair write BC, visible next cycle on stored-read instance.
    pair_write(1, 16'h1234);
    cyc(); idle();
    expect_rd("bc_b", 0, 0, 2, 8'h12);
    expect_rd("bc_c", 0, 1, 3, 8'h34);
    expect_pair("bc_pair", 0, 1, 16'h1234);
    cyc();

    // Flag masking.
    byte_write(1, 8'hFF);
    cyc(); idle();
    expect_rd("f_mask", 0, 0, 1, 8'hF0);
    expect_pair("af_pair", 0, 0, 16'h00F0);
    cyc();

    // Step wrap both directions.
    pair_write(3, 16'hFFFF);
    cyc(); idle();
    step_en = 1; step_sel = 3; step_dec = 0;
    cyc(); idle();
    expect_pair("hl_inc_wrap", 0, 3, 16'h0000);
    step_en = 1; step_sel = 3; step_dec = 1;
    cyc(); idle();
    expect_pair("hl_dec_wrap", 0, 3, 16'hFFFF);
    cyc();

    // Byte write into one half of a stepped pair.
    pair_write(3, 16'h00FF);
    cyc(); idle();
    step_en = 1; step_sel = 3; step_dec = 0;
    byte_write(6, 8'hAA);
    cyc(); idle();
    expect_pair("hl_step_bytewr", 0, 3, 16'hAA00);
    cyc();

    // Pair write beats step and byte write on the same pair.
    pair_write(2, 16'hBEEF);
    step_en = 1; step_sel = 2; step_dec = 0;
    byte_write(4, 8'h11);
    cyc(); idle();
    expect_pair("de_prio", 0, 2, 16'hBEEF);
    cyc();

    // Save with concurrent write, then restore, then ignored restore.
    byte_write(0, 8'h42);
    cyc(); idle();
    save = 1;
    byte_write(0, 8'h99);
    cyc(); idle();
    expect_rd("save_a", 0, 0, 0, 8'h99);
    expect_sv("save_sv", 0, 1'b1);
    cyc();
    restore = 1;
    byte_write(0, 8'h55);
    cyc(); idle();
    expect_rd("restore_a", 0, 0, 0, 8'h42);
    expect_rd("restore_f", 0, 1, 1, 8'hF0);
    expect_pair("restore_hl", 0, 3, 16'hAA00);
    expect_sv("restore_sv", 0, 1'b0);
    cyc();
    restore = 1;
    cyc(); idle();
    expect_rd("restore2_a", 0, 0, 0, 8'h42);
    expect_sv("restore2_sv", 0, 1'b0);
    cyc();

    // Bypass: same-cycle visibility, stored instance still shows old value.
    byte_write(0, 8'h5A);
    expect_rd("byp_a", 1, 0, 0, 8'h5A);
    expect_rd("nobyp_a", 0, 1, 0, 8'h42);
    cyc(); idle();
    byte_write(1, 8'hFF);
    expect_rd("byp_f_mask", 1, 0, 1, 8'hF0);
    cyc(); idle();

    // Step stream, then reset in the middle of it.
    step_en = 1; step_sel = 3; step_dec = 0;
    cyc(); cyc();
    expect_pair("stream_stored", 0, 3, 16'hAA02);
    expect_pair("stream_byp", 1, 3, 16'hAA03);
    rst = 1;
    cyc();
    rst = 0; idle();
    expect_pair("midrst_hl0", 0, 3, 16'h0000);
    expect_rd("midrst_a0", 0, 0, 0, 8'h00);
    expect_sv("midrst_sv0", 0, 1'b0);
    cyc();
    expect_pair("midrst_hl1", 1, 3, 16'h0000);
    expect_rd("midrst_a1", 1, 0, 0, 8'h00);
    cyc();

    repeat (3) cyc();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
